program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//   Front end of the unified RAM's data port (address2/dataIn/writeEnable).
//   After reset, streams a host-supplied program/data image into RAM over a
//   valid/ready handshake while holding the CPU in PC reset. It then releases
//   the CPU and passes the CPU's data-memory signals through to RAM, one
//   registered stage deep. It replaces the bench-only isTesting input toggle.
// PARAMETERS
//   COUNT_WIDTH  16  width of loadWordCount / remaining-word counter
//   ADDR_STEP    4   byte increment between consecutive loaded words
// PORTS
//   clk                 in   1   system clock, all logic on posedge
//   reset               in   1   synchronous, active-high
//   loadStart           in   1   begin load; sampled only in IDLE
//   loadBaseAddress     in   32  first byte address; bits [1:0] forced to 0
//   loadWordCount       in   CW  number of 32-bit words to write
//   loadData            in   32  word to write
//   loadValid           in   1   loadData valid
//   loadReady           out  1   loader accepts loadData this cycle
//   loadDone            out  1   one-cycle pulse on entry to RUN
//   cpuHold             out  1   drives CPU resetPC; 1 = CPU held
//   loadChecksum        out  32  XOR of all accepted words (see CONFIGURATION)
//   addressFromCPU      in   32  CPU data-memory address
//   dataFromCPU         in   32  CPU store data
//   writeEnableFromCPU  in   1   CPU store strobe
//   toMemAddress        out  32  to RAM address2 (registered)
//   toMemWriteData      out  32  to RAM dataIn (registered)
//   toMemWriteEnable    out  1   to RAM writeEnable (registered)
// BEHAVIOUR
//   - Reset (clk posedge with reset=1): state=IDLE. cpuHold=1, loadReady=0,
//     loadDone=0, loadChecksum=0, toMem* = 0. Reset wins over all other inputs.
//   - Reset mid-LOAD abandons the load. Words already written stay in RAM.
//   - IDLE: cpuHold=1, toMemWriteEnable=0.
//     - loadStart=1 and count!=0: latch base address and count, go to LOAD.
//     - loadStart=1 and count==0: go to RUN directly and pulse loadDone.
//   - LOAD: loadReady=1 and cpuHold=1.
//     - Handshake = loadValid & loadReady. On a handshake:
//       - next cycle toMemAddress=curAddr, toMemWriteData=loadData,
//         toMemWriteEnable=1 (1-cycle latency);
//       - curAddr += ADDR_STEP, wrapping modulo 2^32;
//       - remaining -= 1.
//     - With no handshake, toMemWriteEnable=0 on the next cycle.
//     - Handshake with remaining==1 goes to FLUSH, and loadReady drops the
//       next cycle.
//   - FLUSH: exactly one cycle. The last registered write reaches RAM.
//     loadReady=0, cpuHold=1. Then go to RUN and pulse loadDone=1 for the
//     first RUN cycle.
//   - RUN: cpuHold=0, loadReady=0. Each posedge, toMem* <= CPU inputs
//     (pass-through, 1-cycle latency). loadStart and loadValid are ignored.
//     Only reset leaves RUN.
//   - cpuHold falls on the same edge as the loadDone rise. The CPU's first
//     fetch therefore sees the fully written image.
// CONFIGURATION
//   LOADER_CHECKSUM_EN
//     Defined: loadChecksum clears on IDLE->LOAD and XORs in loadData on
//     every handshake. It holds its value in FLUSH and RUN.
//     Undefined: loadChecksum is tied to 32'h0 and no accumulator is built.
// TESTING
//   1. reset; base=500, count=1, data=42 -> one write (500,42,WE=1).
//      loadDone pulses 2 cycles after the handshake. cpuHold=0 after.
//      RAM[500]==42.
//   2. base=0, count=3, loadValid toggling 1,0,1,0,1 -> writes to 0,4,8 in
//      order. No WE on gap cycles. loadReady=0 after the 3rd handshake.
//   3. base=32'hFFFFFFFC, count=2 -> writes at FFFFFFFC then 00000000.
//   4. loadStart with count=0 -> RUN next cycle, loadDone pulse, no RAM write.
//      In RUN, CPU sw (addr 128, data 7, WE 1) -> toMem* match 1 cycle later.
//   5. reset asserted after 2 of 4 handshakes -> next cycle IDLE, cpuHold=1,
//      toMemWriteEnable=0. loadStart/loadValid in RUN are ignored.
//   6. LOADER_CHECKSUM_EN, words 0xF0F0_0000 and 0x0F0F_FFFF ->
//      loadChecksum=0xFFFF_FFFF. Macro off -> 0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: streams a host image into RAM while holding the CPU, then passes CPU data-memory traffic through.
// Optional LOADER_CHECKSUM_EN builds an XOR accumulator of accepted words on loadChecksum.
module program_loader #(
  parameter int COUNT_WIDTH = 16,
  parameter int ADDR_STEP   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   loadStart,
  input  logic [31:0]            loadBaseAddress,
  input  logic [COUNT_WIDTH-1:0] loadWordCount,
  input  logic [31:0]            loadData,
  input  logic                   loadValid,
  output logic                   loadReady,
  output logic                   loadDone,
  output logic                   cpuHold,
  output logic [31:0]            loadChecksum,
  input  logic [31:0]            addressFromCPU,
  input  logic [31:0]            dataFromCPU,
  input  logic                   writeEnableFromCPU,
  output logic [31:0]            toMemAddress,
  output logic [31:0]            toMemWriteData,
  output logic                   toMemWriteEnable
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;
  state_t state_q, state_d;
  logic [31:0] cur_q, cur_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic we_q, we_d, done_q, done_d, hs, start_load;
  assign hs = (state_q == LOAD) & loadValid;
  assign start_load = (state_q == IDLE) & loadStart & (loadWordCount != '0);
  assign loadReady = state_q == LOAD;
  assign cpuHold = state_q != RUN;
  assign loadDone = done_q;
  assign toMemAddress = addr_q;
  assign toMemWriteData = wdata_q;
  assign toMemWriteEnable = we_q;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    rem_d = rem_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (loadStart) begin
        cur_d = {loadBaseAddress[31:2], 2'b00};
        rem_d = loadWordCount;
        state_d = start_load ? LOAD : RUN;
        done_d = !start_load;
      end
      LOAD: if (hs) begin
        addr_d = cur_q;
        wdata_d = loadData;
        we_d = 1'b1;
        cur_d = cur_q + 32'(ADDR_STEP);
        rem_d = rem_q - 1'b1;
        state_d = (rem_q == COUNT_WIDTH'(1)) ? FLUSH : LOAD;
      end
      FLUSH: begin
        state_d = RUN;
        done_d = 1'b1;
      end
      default: begin
        addr_d = addressFromCPU;
        wdata_d = dataFromCPU;
        we_d = writeEnableFromCPU;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q <= '0;
      rem_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      rem_q <= rem_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      done_q <= done_d;
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] cs_q, cs_d;
  assign cs_d = start_load ? '0 : hs ? cs_q ^ loadData : cs_q;
  always_ff @(posedge clk) begin
    if (reset) cs_q <= '0;
    else cs_q <= cs_d;
  end
  assign loadChecksum = cs_q;
`else
  assign loadChecksum = '0;
`endif
endmodule
